// File: rtl/fork_dispatcher_pkg.sv
// fork_dispatcher_pkg: inter-CPU message codes, bus widths and dispatcher FSM encoding
// shared by the fork dispatcher and its queue.
package fork_dispatcher_pkg;
   localparam int ADDR_SIZE = 32;
   localparam int DATA_SIZE = 32;
   localparam logic [7:0] CPU_R_FORK_THRD = 8'h11;
   localparam logic [7:0] CPU_R_FORK_DONE = 8'h12;
   localparam logic [7:0] CPU_R_STOP_THRD = 8'h14;
   typedef enum logic [1:0] {FD_IDLE, FD_HOLD, FD_ACK, FD_DRAIN} fd_state_e;
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/fork_queue.sv
// fork_queue: circular FIFO of pending forks; extra pointer MSB tells full from empty,
// head is read combinationally from the registered array.
module fork_queue #(
   parameter int DEPTH = 4,
   parameter int W = 64,
   localparam int AW = $clog2(DEPTH) + 1
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic [W-1:0] din,
   output logic full,
   output logic empty,
   output logic [W-1:0] head,
   output logic [AW-1:0] count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW-1] != rd_ptr[AW-1]) && (wr_ptr[AW-2:0] == rd_ptr[AW-2:0]);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head = mem[rd_ptr[AW-2:0]];
   assign count = wr_ptr - rd_ptr;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-2:0]] <= din;
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      end
   end
endmodule

// File: rtl/fork_dispatcher.sv
// fork_dispatcher: answers CPU_R_FORK_THRD with CPU_R_FORK_DONE, queues forks for the scheduler
// and counts stop notifications. Optional statistics outputs under FORK_DISP_STATS_EN.
module fork_dispatcher
   import fork_dispatcher_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ACK_CYCLES = 1,
   localparam int AW = $clog2(DEPTH) + 1
) (
   input logic clk,
   input logic rst,
   inout wire [7:0] cpu_msg,
   input logic [ADDR_SIZE-1:0] addr,
   input logic [DATA_SIZE-1:0] data,
   output logic disp_online,
   output logic thrd_valid,
   input logic thrd_ready,
   output logic [ADDR_SIZE-1:0] thrd_addr,
   output logic [DATA_SIZE-1:0] thrd_param,
   output logic stop_pulse,
`ifdef FORK_DISP_STATS_EN
   output logic [15:0] fork_count,
   output logic [15:0] overflow_count,
   output logic [AW-1:0] max_occupancy,
`endif
   output logic [15:0] stop_count
);
   localparam int QW = ADDR_SIZE + DATA_SIZE;
   fd_state_e state, state_n;
   logic [1:0] ack_cnt;
   logic [QW-1:0] hold_q, head;
   logic [AW-1:0] occ;
   logic q_full, q_empty, push, pop, drive, is_fork, is_stop, stop_prev, stop_hit;
   assign is_fork = cpu_msg === CPU_R_FORK_THRD;
   assign is_stop = cpu_msg === CPU_R_STOP_THRD;
   assign push = state == FD_ACK && ack_cnt == 2'd0;
   assign pop = thrd_ready && !q_empty;
   assign drive = state == FD_ACK && ack_cnt != 2'd0 && !rst;
   assign stop_hit = state == FD_IDLE && is_stop && !stop_prev;
   assign cpu_msg = drive ? CPU_R_FORK_DONE : 'z;
   assign thrd_valid = !q_empty;
   assign {thrd_addr, thrd_param} = head;
   fork_queue #(.DEPTH(DEPTH), .W(QW)) u_queue (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(hold_q),
      .full(q_full),
      .empty(q_empty),
      .head(head),
      .count(occ)
   );
   // A pop in the same cycle frees the slot the held fork is waiting for.
   always_comb begin
      state_n = state;
      case (state)
         FD_IDLE:  if (is_fork) state_n = q_full ? FD_HOLD : FD_ACK;
         FD_HOLD:  if (!q_full || pop) state_n = FD_ACK;
         FD_ACK:   if (ack_cnt == 2'(ACK_CYCLES)) state_n = FD_DRAIN;
         FD_DRAIN: if (!is_fork) state_n = FD_IDLE;
         default:  state_n = FD_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FD_IDLE;
         ack_cnt <= 2'd0;
         hold_q <= '0;
         disp_online <= 1'b0;
         stop_prev <= 1'b0;
         stop_pulse <= 1'b0;
         stop_count <= 16'd0;
      end else begin
         state <= state_n;
         ack_cnt <= (state == FD_ACK && state_n == FD_ACK) ? ack_cnt + 2'd1 : 2'd0;
         if (state == FD_IDLE && is_fork) hold_q <= {addr, data};
         disp_online <= state == FD_IDLE && occ != AW'(DEPTH);
         stop_prev <= is_stop;
         stop_pulse <= stop_hit;
         if (stop_hit) stop_count <= sat_inc16(stop_count);
      end
   end
`ifdef FORK_DISP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fork_count <= 16'd0;
         overflow_count <= 16'd0;
         max_occupancy <= '0;
      end else begin
         if (push) fork_count <= sat_inc16(fork_count);
         if (state == FD_IDLE && state_n == FD_HOLD) overflow_count <= sat_inc16(overflow_count);
         if (occ > max_occupancy) max_occupancy <= occ;
      end
   end
`endif
endmodule
